// File: rtl/read_returner.sv
// Read/write completion return stage: reorders out-of-order read completions
// into request-index order and forwards write acknowledges through a small FIFO.
module read_returner #(
    parameter int DATA_WIDTH   = 16,
    parameter int INDEX_WIDTH  = 6,
    parameter int WR_ACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_type,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [INDEX_WIDTH-1:0] in_index,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   wr_ack_valid,
    input  logic                   wr_ack_ready,
    output logic [INDEX_WIDTH-1:0] wr_ack_index,
    output logic [INDEX_WIDTH:0]   rob_count,
    output logic                   err_dup,
    output logic                   err_ovf
);

    localparam int SLOTS = 2 ** INDEX_WIDTH;
    localparam int AW    = $clog2(WR_ACK_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CW    = INDEX_WIDTH + 1;

    logic [SLOTS-1:0]       slotValid_q, slotValid_d;
    logic [DATA_WIDTH-1:0]  slotData_q [SLOTS];
    logic [INDEX_WIDTH-1:0] head_q, head_d;
    logic                   rdValid_q, rdValid_d;
    logic [DATA_WIDTH-1:0]  rdData_q, rdData_d;
    logic [INDEX_WIDTH-1:0] rdIndex_q, rdIndex_d;
    logic [CW-1:0]          robCount_q, robCount_d;
    logic                   errDup_q, errDup_d;
    logic                   errOvf_q, errOvf_d;
    logic [INDEX_WIDTH-1:0] fifo_q [WR_ACK_DEPTH];
    logic [PW-1:0]          wrPtr_q, wrPtr_d;
    logic [PW-1:0]          rdPtr_q, rdPtr_d;

    logic          rdArrive, wrArrive, outFree, load, drainHit, rdAccept;
    logic [PW-1:0] fifoCount;
    logic          fifoEmpty, fifoFull, pop, push;

    assign rdArrive  = in_valid & ~in_type;
    assign wrArrive  = in_valid & in_type;
    assign outFree   = ~rdValid_q | rd_ready;
    assign load      = outFree & slotValid_q[head_q];
    // An arrival into the slot being drained this edge replaces the stale entry.
    assign drainHit  = load & (in_index == head_q);
    assign rdAccept  = rdArrive & (~slotValid_q[in_index] | drainHit);
    assign fifoCount = wrPtr_q - rdPtr_q;
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (fifoCount == PW'(WR_ACK_DEPTH));
    assign pop       = ~fifoEmpty & wr_ack_ready;
    assign push      = wrArrive & (~fifoFull | pop);

    always_comb begin
        slotValid_d = slotValid_q;
        head_d      = head_q;
        rdValid_d   = rdValid_q;
        rdData_d    = rdData_q;
        rdIndex_d   = rdIndex_q;
        robCount_d  = robCount_q;
        errDup_d    = errDup_q | (rdArrive & slotValid_q[in_index] & ~drainHit);
        errOvf_d    = errOvf_q | (wrArrive & fifoFull & ~pop);
        wrPtr_d     = wrPtr_q + PW'(push);
        rdPtr_d     = rdPtr_q + PW'(pop);

        if (load) begin
            slotValid_d[head_q] = 1'b0;
        end
        if (rdAccept) begin
            slotValid_d[in_index] = 1'b1;
        end

        if (outFree) begin
            rdValid_d = load;
            if (load) begin
                rdData_d  = slotData_q[head_q];
                rdIndex_d = head_q;
                head_d    = head_q + INDEX_WIDTH'(1);
            end
        end

        case ({rdAccept, load})
            2'b10:   robCount_d = robCount_q + CW'(1);
            2'b01:   robCount_d = robCount_q - CW'(1);
            default: robCount_d = robCount_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slotValid_q <= '0;
            head_q      <= '0;
            rdValid_q   <= 1'b0;
            rdData_q    <= '0;
            rdIndex_q   <= '0;
            robCount_q  <= '0;
            errDup_q    <= 1'b0;
            errOvf_q    <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            slotValid_q <= slotValid_d;
            head_q      <= head_d;
            rdValid_q   <= rdValid_d;
            rdData_q    <= rdData_d;
            rdIndex_q   <= rdIndex_d;
            robCount_q  <= robCount_d;
            errDup_q    <= errDup_d;
            errOvf_q    <= errOvf_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
        end
    end

    // Storage arrays need no reset; their valid bits and pointers guard them.
    always_ff @(posedge clk) begin
        if (rdAccept) begin
            slotData_q[in_index] <= in_data;
        end
        if (push) begin
            fifo_q[wrPtr_q[AW-1:0]] <= in_index;
        end
    end

    assign rd_valid     = rdValid_q;
    assign rd_data      = rdData_q;
    assign rd_index     = rdIndex_q;
    assign wr_ack_valid = ~fifoEmpty;
    assign wr_ack_index = fifoEmpty ? '0 : fifo_q[rdPtr_q[AW-1:0]];
    assign rob_count    = robCount_q;
    assign err_dup      = errDup_q;
    assign err_ovf      = errOvf_q;

endmodule

// File: tb/tb_read_returner.sv
// Bench for read_returner: directed scenarios plus randomized traffic checked
// against an index-ordered release model and an ideal acknowledge queue.
module tb_read_returner;

    localparam int DW    = 16;
    localparam int IW    = 6;
    localparam int AD    = 4;
    localparam int SLOTS = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_type;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_index;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] rd_index;
    logic          wr_ack_valid, wr_ack_ready;
    logic [IW-1:0] wr_ack_index;
    logic [IW:0]   rob_count;
    logic          err_dup, err_ovf;

    int total = 0;
    int bad   = 0;

    logic [IW+DW-1:0] gotRd[$], expRd[$];
    logic [IW-1:0]    gotAck[$], expAck[$];
    logic [IW-1:0]    mFifo[$];
    bit               mFlag [SLOTS];
    logic [DW-1:0]    mData [SLOTS];
    int               mHead;
    bit               mDup, mOvf;

    always #5 clk = ~clk;

    read_returner #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WR_ACK_DEPTH(AD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_type(in_type), .in_data(in_data), .in_index(in_index),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_index(rd_index),
        .wr_ack_valid(wr_ack_valid), .wr_ack_ready(wr_ack_ready), .wr_ack_index(wr_ack_index),
        .rob_count(rob_count), .err_dup(err_dup), .err_ovf(err_ovf)
    );

    // Record every completed handshake; inputs are stable mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid && rd_ready) gotRd.push_back({rd_index, rd_data});
            if (wr_ack_valid && wr_ack_ready) gotAck.push_back(wr_ack_index);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < SLOTS; i++) mFlag[i] = 1'b0;
        mHead = 0;
        mDup  = 1'b0;
        mOvf  = 1'b0;
        mFifo.delete();
        expRd.delete();
        expAck.delete();
        gotRd.delete();
        gotAck.delete();
    endtask

    task automatic doReset();
        in_valid = 0; in_type = 0; in_data = '0; in_index = '0;
        rd_ready = 1; wr_ack_ready = 1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    // Drives one cycle of inputs, lets the model consume it, returns 1 time unit after the edge.
    task automatic applyStimulus(input bit v, input bit t, input logic [DW-1:0] d,
                                 input logic [IW-1:0] idx, input bit rr, input bit wr);
        int sz;
        bit popNow, fullNow;
        in_valid = v; in_type = t; in_data = d; in_index = idx;
        rd_ready = rr; wr_ack_ready = wr;
        sz      = mFifo.size();
        popNow  = (sz > 0) && wr;
        fullNow = (sz == AD);
        if (popNow) expAck.push_back(mFifo.pop_front());
        if (v && t) begin
            if (!fullNow || popNow) mFifo.push_back(idx);
            else mOvf = 1'b1;
        end
        if (v && !t) begin
            if (mFlag[idx]) mDup = 1'b1;
            else begin
                mFlag[idx] = 1'b1;
                mData[idx] = d;
            end
            while (mFlag[mHead]) begin
                expRd.push_back({IW'(mHead), mData[mHead]});
                mFlag[mHead] = 1'b0;
                mHead = (mHead + 1) % SLOTS;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rr, input bit wr, input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, rr, wr);
    endtask

    task automatic compareReads(input string tag);
        checkOutput({tag, "_rdcount"}, gotRd.size(), expRd.size());
        for (int i = 0; i < expRd.size(); i++)
            checkOutput({tag, "_rd"}, (i < gotRd.size()) ? 32'(gotRd[i]) : 32'hDEAD_BEEF, 32'(expRd[i]));
    endtask

    task automatic compareAcks(input string tag);
        checkOutput({tag, "_ackcount"}, gotAck.size(), expAck.size());
        for (int i = 0; i < expAck.size(); i++)
            checkOutput({tag, "_ack"}, (i < gotAck.size()) ? 32'(gotAck[i]) : 32'hDEAD_BEEF, 32'(expAck[i]));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int    win[8];
        int    sent;
        int    r;
        int    j, tmp;
        logic [31:0] pk;

        // Reset state
        doReset();
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_rd_index", rd_index, 0);
        checkOutput("rst_wr_ack_valid", wr_ack_valid, 0);
        checkOutput("rst_wr_ack_index", wr_ack_index, 0);
        checkOutput("rst_rob_count", rob_count, 0);
        checkOutput("rst_errs", {err_dup, err_ovf}, 0);

        // In-order reads with one-cycle latency
        applyStimulus(1, 0, 16'hA0, 0, 1, 1);
        checkOutput("io_latency", rd_valid, 0);
        applyStimulus(1, 0, 16'hA1, 1, 1, 1);
        checkOutput("io_first", {rd_valid, rd_index, rd_data}, {1'b1, 6'd0, 16'hA0});
        applyStimulus(1, 0, 16'hA2, 2, 1, 1);
        checkOutput("io_second", {rd_valid, rd_index, rd_data}, {1'b1, 6'd1, 16'hA1});
        idle(1, 1, 1);
        checkOutput("io_third", {rd_valid, rd_index, rd_data}, {1'b1, 6'd2, 16'hA2});
        idle(1, 1, 1);
        checkOutput("io_done_valid", rd_valid, 0);
        checkOutput("io_done_count", rob_count, 0);
        compareReads("io");

        // Reordering
        doReset();
        applyStimulus(1, 0, 16'hB2, 2, 1, 1);
        checkOutput("ro_hold2", rd_valid, 0);
        applyStimulus(1, 0, 16'hB1, 1, 1, 1);
        checkOutput("ro_hold1", rd_valid, 0);
        applyStimulus(1, 0, 16'hB3, 3, 1, 1);
        checkOutput("ro_hold3", rd_valid, 0);
        checkOutput("ro_count", rob_count, 3);
        applyStimulus(1, 0, 16'hB0, 0, 1, 1);
        checkOutput("ro_hold0", rd_valid, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1, 1, 1);
            checkOutput("ro_emit", {rd_valid, rd_index}, {1'b1, 6'(k)});
        end
        idle(1, 1, 1);
        checkOutput("ro_done", rd_valid, 0);
        compareReads("ro");

        // Backpressure
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 16'hC0 + 16'(k), 6'(k), 0, 1);
        for (int k = 0; k < 5; k++) begin
            idle(0, 1, 1);
            checkOutput("bp_hold", {rd_valid, rd_index, rd_data}, {1'b1, 6'd0, 16'hC0});
        end
        checkOutput("bp_count", rob_count, 3);
        for (int k = 1; k < 4; k++) begin
            idle(1, 1, 1);
            checkOutput("bp_release", {rd_valid, rd_index, rd_data}, {1'b1, 6'(k), 16'hC0 + 16'(k)});
        end
        idle(1, 1, 1);
        checkOutput("bp_done", rd_valid, 0);
        compareReads("bp");

        // Wrap-around of the head pointer
        doReset();
        for (int n = 0; n < 70; n++) applyStimulus(1, 0, 16'h100 + 16'(n), 6'(n % 64), 1, 1);
        idle(1, 1, 3);
        pk = (gotRd.size() > 63) ? 32'(gotRd[63][IW+DW-1:DW]) : 32'hFFFF;
        checkOutput("wrap_63", pk, 63);
        pk = (gotRd.size() > 64) ? 32'(gotRd[64][IW+DW-1:DW]) : 32'hFFFF;
        checkOutput("wrap_64", pk, 0);
        pk = (gotRd.size() > 69) ? 32'(gotRd[69][IW+DW-1:DW]) : 32'hFFFF;
        checkOutput("wrap_69", pk, 5);
        checkOutput("wrap_dup", err_dup, 0);
        compareReads("wrap");

        // Duplicate arrival
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 0, 16'h40 + 16'(k), 6'(k), 1, 1);
        idle(1, 1, 2);
        applyStimulus(1, 0, 16'h55, 5, 1, 1);
        checkOutput("dup_first", {err_dup, rob_count}, {1'b0, 7'd1});
        applyStimulus(1, 0, 16'h66, 5, 1, 1);
        checkOutput("dup_second", {err_dup, rob_count}, {mDup, 7'd1});
        applyStimulus(1, 0, 16'h44, 4, 1, 1);
        idle(1, 1, 3);
        checkOutput("dup_sticky", err_dup, 1);
        checkOutput("dup_drained", {rd_valid, rob_count}, 0);
        compareReads("dup");
        doReset();
        checkOutput("dup_cleared", err_dup, 0);

        // Write-acknowledge FIFO and overflow
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, '0, 6'(9 + k), 1, 0);
            checkOutput("wr_head", {wr_ack_valid, wr_ack_index}, {1'b1, 6'd9});
            checkOutput("wr_ovf", err_ovf, (k == 4) ? 1 : 0);
        end
        applyStimulus(1, 0, 16'hD0, 0, 1, 1);
        idle(1, 1, 5);
        checkOutput("wr_drained", wr_ack_valid, 0);
        checkOutput("wr_ovf_sticky", err_ovf, mOvf);
        checkOutput("wr_count", gotAck.size(), 4);
        compareAcks("wr");
        compareReads("wr");

        // Randomized traffic: shuffled read windows interleaved with writes
        doReset();
        for (int round = 0; round < 12; round++) begin
            for (int i = 0; i < 8; i++) win[i] = (mHead + i) % SLOTS;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = win[i]; win[i] = win[j]; win[j] = tmp;
            end
            sent = 0;
            while (sent < 8) begin
                r = $urandom_range(0, 3);
                if (r == 0)
                    applyStimulus(1, 1, '0, 6'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
                else if (r == 1)
                    applyStimulus(0, 0, '0, '0, $urandom_range(0, 1), $urandom_range(0, 1));
                else begin
                    applyStimulus(1, 0, 16'($urandom), 6'(win[sent]), $urandom_range(0, 1), $urandom_range(0, 1));
                    sent++;
                end
            end
            idle(1, $urandom_range(0, 1), 12);
        end
        idle(1, 1, 8);
        compareReads("rand");
        compareAcks("rand");
        checkOutput("rand_dup", err_dup, mDup);
        checkOutput("rand_ovf", err_ovf, mOvf);
        checkOutput("rand_empty", {rd_valid, wr_ack_valid, rob_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
